// File: rtl/trivium_pkg.sv
// Purpose: shared widths, tap positions, FSM encoding and round helpers for the Trivium keystream path.
// Latency: none (declarations and pure functions only).
// Backpressure: none here; callers decide when a round is applied.
package trivium_pkg;

    localparam int KEY_W = 80;
    localparam int IV_W  = 80;
    localparam int ST_W  = 288;

    // Shift-register boundaries: A = s1..s93, B = s94..s177, C = s178..s288
    localparam int A_END = 93;
    localparam int B_END = 177;

    // Tap positions, 1-based as in the cipher description; bit s_i lives at vector index i-1
    localparam int T66  = 66;
    localparam int T69  = 69;
    localparam int T91  = 91;
    localparam int T92  = 92;
    localparam int T93  = 93;
    localparam int T162 = 162;
    localparam int T171 = 171;
    localparam int T175 = 175;
    localparam int T176 = 176;
    localparam int T177 = 177;
    localparam int T243 = 243;
    localparam int T264 = 264;
    localparam int T286 = 286;
    localparam int T287 = 287;
    localparam int T288 = 288;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    // Initial state: key into s1..s80, iv into s94..s173, s286..s288 set, everything else clear
    function automatic logic [ST_W-1:0] trivium_load(input logic [KEY_W-1:0] key,
                                                     input logic [IV_W-1:0]  iv);
        logic [ST_W-1:0] s;
        s                         = '0;
        s[KEY_W-1:0]              = key;
        s[A_END+IV_W-1:A_END]     = iv;
        s[ST_W-1:ST_W-3]          = 3'b111;
        return s;
    endfunction

    // One cipher round: returns {z, next_state}
    function automatic logic [ST_W:0] trivium_step(input logic [ST_W-1:0] s);
        logic t1;
        logic t2;
        logic t3;
        logic z;
        t1 = s[T66-1]  ^ s[T93-1];
        t2 = s[T162-1] ^ s[T177-1];
        t3 = s[T243-1] ^ s[T288-1];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (s[T91-1]  & s[T92-1])  ^ s[T171-1];
        t2 = t2 ^ (s[T175-1] & s[T176-1]) ^ s[T264-1];
        t3 = t3 ^ (s[T286-1] & s[T287-1]) ^ s[T69-1];
        return {z, s[ST_W-2:B_END], t2, s[B_END-2:A_END], t1, s[A_END-2:0], t3};
    endfunction

endpackage

// File: rtl/trivium_round.sv
// Purpose: unrolls P Trivium rounds; outputs the advanced state and the P keystream bits.
// Latency: purely combinational.
// Backpressure: none; the owner of the state register chooses whether to take st_out.
module trivium_round
    import trivium_pkg::*;
#(
    parameter int P = 1
) (
    input  logic [ST_W-1:0] st_in,
    output logic [ST_W-1:0] st_out,
    output logic [P-1:0]    z
);

    logic [ST_W-1:0] s;
    logic [ST_W:0]   r;

    // Chain P rounds; the first round's output bit lands in z[0]
    always_comb begin
        s = st_in;
        r = '0;
        z = '0;
        for (int k = 0; k < P; k++) begin
            r    = trivium_step(s);
            z[k] = r[ST_W];
            s    = r[ST_W-1:0];
        end
        st_out = s;
    end

endmodule

// File: rtl/trivium_ks_ctrl.sv
// Purpose: Trivium sequencer; loads key/iv, discards WARMUP steps, then packs keystream into W-bit words.
// Latency: first ks_valid WARMUP/P + W/P clocks after the accepted start; P==W then gives one word per clock.
// Backpressure: rounds stall while ks_valid && !ks_ready, so no keystream bit is dropped; ks_data is held.
module trivium_ks_ctrl
    import trivium_pkg::*;
#(
    parameter int P      = 1,
    parameter int W      = 8,
    parameter int WARMUP = 1152
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [KEY_W-1:0] key,
    input  logic [IV_W-1:0]  iv,
    output logic             busy,
    output logic [W-1:0]     ks_data,
    output logic             ks_valid,
    input  logic             ks_ready
);

    localparam int NBEAT  = W / P;
    localparam int BEAT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam int CNT_W  = $clog2(WARMUP + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEAT - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WARMUP - P);
    localparam logic [CNT_W-1:0]  CNT_INC   = CNT_W'(P);

    if (!(P == 1 || P == 2 || P == 4 || P == 8 || P == 16 || P == 32 || P == 64)) begin : g_bad_p
        $error("trivium_ks_ctrl: P must be one of 1,2,4,8,16,32,64");
    end
    if (W < P || (W % P) != 0) begin : g_bad_w
        $error("trivium_ks_ctrl: W must be a non-zero multiple of P");
    end
    if (WARMUP < P || (WARMUP % P) != 0) begin : g_bad_warmup
        $error("trivium_ks_ctrl: WARMUP must be a non-zero multiple of P");
    end

    state_t            fsm;
    logic [ST_W-1:0]   st;
    logic [ST_W-1:0]   st_nxt;
    logic [P-1:0]      z;
    logic [CNT_W-1:0]  cnt;
    logic [W-1:0]      acc;
    logic [W-1:0]      acc_fill;
    logic [BEAT_W-1:0] beat;
    logic              adv;

    trivium_round #(.P(P)) u_round (
        .st_in  (st),
        .st_out (st_nxt),
        .z      (z)
    );

    // Rounds may only run when the output slot is free or being drained this cycle
    assign adv  = !ks_valid || ks_ready;
    assign busy = (fsm != S_IDLE);

    // Accumulator with this clock's P bits dropped into the current beat slot
    always_comb begin
        acc_fill = acc;
        acc_fill[int'(beat) * P +: P] = z;
    end

    // Sequencer, cipher state, warm-up counter, word packer and output slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm      <= S_IDLE;
            st       <= '0;
            cnt      <= '0;
            acc      <= '0;
            beat     <= '0;
            ks_data  <= '0;
            ks_valid <= 1'b0;
        end else if (fsm != S_IDLE && stop) begin
            fsm      <= S_IDLE;
            st       <= '0;
            cnt      <= '0;
            acc      <= '0;
            beat     <= '0;
            ks_data  <= '0;
            ks_valid <= 1'b0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (start) begin
                        st  <= trivium_load(key, iv);
                        cnt <= '0;
                        fsm <= S_WARMUP;
                    end
                end
                S_WARMUP: begin
                    st  <= st_nxt;
                    cnt <= cnt + CNT_INC;
                    if (cnt == LAST_CNT) begin
                        fsm <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (adv) begin
                        st <= st_nxt;
                        if (beat == LAST_BEAT) begin
                            ks_data  <= acc_fill;
                            ks_valid <= 1'b1;
                            acc      <= '0;
                            beat     <= '0;
                        end else begin
                            acc  <= acc_fill;
                            beat <= beat + 1'b1;
                            // adv with a word present means it was consumed this clock
                            if (ks_valid) begin
                                ks_valid <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    fsm <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trivium_ks_ctrl.sv
// Purpose: directed bench for trivium_ks_ctrl against a bit-serial software cipher model.
// Latency: checks first-word timing for three parameter sets and per-word spacing.
// Backpressure: random ks_ready stalls with hold checks and scoreboard ordering.
module tb_trivium_ks_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start_v;
    logic [2:0]  stop_v;
    logic [2:0]  busy_v;
    logic [2:0]  valid_v;
    logic [79:0] key;
    logic [79:0] iv;
    logic        ks_ready;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [15:0] d2;

    int nvec = 0;
    int nmis = 0;

    logic [15:0] sbq[$];
    bit          ms[1:288];

    always #5 clk = ~clk;

    trivium_ks_ctrl #(.P(1), .W(8), .WARMUP(1152)) u_p1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .stop(stop_v[0]), .key(key), .iv(iv),
        .busy(busy_v[0]), .ks_data(d0), .ks_valid(valid_v[0]), .ks_ready(ks_ready)
    );

    trivium_ks_ctrl #(.P(8), .W(8), .WARMUP(1152)) u_p8 (
        .clk(clk), .rst(rst), .start(start_v[1]), .stop(stop_v[1]), .key(key), .iv(iv),
        .busy(busy_v[1]), .ks_data(d1), .ks_valid(valid_v[1]), .ks_ready(ks_ready)
    );

    trivium_ks_ctrl #(.P(4), .W(16), .WARMUP(16)) u_p4 (
        .clk(clk), .rst(rst), .start(start_v[2]), .stop(stop_v[2]), .key(key), .iv(iv),
        .busy(busy_v[2]), .ks_data(d2), .ks_valid(valid_v[2]), .ks_ready(ks_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- bit-serial reference model ----------------
    task automatic model_step(output bit zo);
        bit t1, t2, t3;
        t1 = ms[66]  ^ ms[93];
        t2 = ms[162] ^ ms[177];
        t3 = ms[243] ^ ms[288];
        zo = t1 ^ t2 ^ t3;
        t1 = t1 ^ (ms[91]  & ms[92])  ^ ms[171];
        t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
        t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
        for (int i = 93; i >= 2; i--)   ms[i] = ms[i-1];
        ms[1] = t3;
        for (int i = 177; i >= 95; i--) ms[i] = ms[i-1];
        ms[94] = t1;
        for (int i = 288; i >= 179; i--) ms[i] = ms[i-1];
        ms[178] = t2;
    endtask

    task automatic model_load(input logic [79:0] k, input logic [79:0] v, input int warm);
        bit zd;
        for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            ms[i]      = k[i-1];
            ms[93 + i] = v[i-1];
        end
        ms[286] = 1'b1;
        ms[287] = 1'b1;
        ms[288] = 1'b1;
        for (int i = 0; i < warm; i++) model_step(zd);
    endtask

    task automatic model_push(input int w, input int n);
        bit          zb;
        logic [15:0] word;
        for (int j = 0; j < n; j++) begin
            word = '0;
            for (int b = 0; b < w; b++) begin
                model_step(zb);
                word[b] = zb;
            end
            sbq.push_back(word);
        end
    endtask

    // ---------------- DUT access helpers ----------------
    function automatic logic [15:0] get_data(input int sel);
        case (sel)
            0:       return {8'h00, d0};
            1:       return {8'h00, d1};
            default: return d2;
        endcase
    endfunction

    // Called at a negedge; the following posedge is the start edge
    task automatic do_start(input int sel, input logic [79:0] k, input logic [79:0] v, input logic with_stop);
        key           = k;
        iv            = v;
        start_v[sel]  = 1'b1;
        stop_v[sel]   = with_stop;
        @(negedge clk);
        start_v = '0;
        stop_v  = '0;
        key     = ~k;
        iv      = ~v;
    endtask

    task automatic wait_valid(input int sel, input int budget, output int lat);
        lat = 0;
        while (!valid_v[sel] && lat < budget) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Drain n words from DUT sel; rnd gives ~30% ready-low; gap>0 checks handshake spacing
    task automatic stream(input int sel, input int n, input bit rnd, input int gap, input string tag);
        int          got;
        int          iter;
        int          last;
        int          limit;
        logic        v;
        logic        stall;
        logic [15:0] d;
        logic [15:0] held;
        logic [15:0] exp;
        got   = 0;
        iter  = 0;
        last  = -1;
        limit = n * 12 + 64;
        stall = 1'b0;
        held  = '0;
        while (got < n && iter < limit) begin
            v = valid_v[sel];
            d = get_data(sel);
            if (stall) begin
                check($sformatf("%s_hold_vld", tag), 64'(v), 64'(1));
                check($sformatf("%s_hold_dat", tag), 64'(d), 64'(held));
            end
            ks_ready = rnd ? ($urandom_range(0, 9) >= 3) : 1'b1;
            if (v && ks_ready) begin
                check($sformatf("%s_sb_nonempty", tag), 64'(sbq.size() != 0), 64'(1));
                exp = (sbq.size() != 0) ? sbq.pop_front() : 16'hxxxx;
                check($sformatf("%s_word%0d", tag, got), 64'(d), 64'(exp));
                if (gap > 0 && last >= 0) begin
                    check($sformatf("%s_gap%0d", tag, got), 64'(iter - last), 64'(gap));
                end
                last = iter;
                got++;
            end
            stall = v && !ks_ready;
            held  = d;
            @(negedge clk);
            iter++;
        end
        ks_ready = 1'b0;
        check($sformatf("%s_count", tag), 64'(got), 64'(n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst      = 1'b1;
        start_v  = '0;
        stop_v   = '0;
        key      = '0;
        iv       = '0;
        ks_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values on all three instances
        for (int s = 0; s < 3; s++) begin
            check($sformatf("rst_busy%0d", s), 64'(busy_v[s]), 64'(0));
            check($sformatf("rst_vld%0d", s), 64'(valid_v[s]), 64'(0));
            check($sformatf("rst_dat%0d", s), 64'(get_data(s)), 64'(0));
        end
        rst = 1'b0;
        @(negedge clk);

        // 1: P=1 W=8, zero key/iv, 1160-clock latency, 8 clocks per word
        model_load(80'h0, 80'h0, 1152);
        model_push(8, 64);
        do_start(0, 80'h0, 80'h0, 1'b0);
        ks_ready = 1'b1;
        wait_valid(0, 3000, lat);
        check("t1_latency", 64'(lat), 64'(1160));
        stream(0, 64, 1'b0, 8, "t1");
        check("t1_drained", 64'(sbq.size()), 64'(0));

        // 4a: stop in WARMUP at cnt=500
        stop_v[0] = 1'b1;
        @(negedge clk);
        stop_v[0] = 1'b0;
        do_start(0, 80'h13579BDF02468ACE1357, 80'h0F1E2D3C4B5A69788796, 1'b0);
        repeat (500) @(negedge clk);
        check("t4_busy_warm", 64'(busy_v[0]), 64'(1));
        stop_v[0] = 1'b1;
        @(negedge clk);
        stop_v[0] = 1'b0;
        check("t4_warm_stop_busy", 64'(busy_v[0]), 64'(0));
        check("t4_warm_stop_vld", 64'(valid_v[0]), 64'(0));

        // 2: P=8 W=8, 145-clock latency, one word per clock
        model_load(80'h0123456789ABCDEF0123, 80'hFEDCBA9876543210FEDC, 1152);
        model_push(8, 256);
        do_start(1, 80'h0123456789ABCDEF0123, 80'hFEDCBA9876543210FEDC, 1'b0);
        ks_ready = 1'b1;
        wait_valid(1, 400, lat);
        check("t2_latency", 64'(lat), 64'(145));
        stream(1, 256, 1'b0, 1, "t2");

        // 3: random backpressure on the continuing stream
        model_push(8, 512);
        stream(1, 512, 1'b1, 0, "t3");
        check("t3_drained", 64'(sbq.size()), 64'(0));

        // 5a: start while streaming is ignored
        start_v[1] = 1'b1;
        key        = 80'hDEADBEEFDEADBEEFDEAD;
        @(negedge clk);
        start_v[1] = 1'b0;
        check("t5_busy_after_start", 64'(busy_v[1]), 64'(1));
        model_push(8, 32);
        stream(1, 32, 1'b0, 1, "t5_ign");

        // 4b: start&&stop while busy with a stalled word -> stop wins
        ks_ready = 1'b0;
        wait_valid(1, 20, lat);
        check("t4_pending_vld", 64'(valid_v[1]), 64'(1));
        start_v[1] = 1'b1;
        stop_v[1]  = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        stop_v[1]  = 1'b0;
        check("t4_stream_stop_busy", 64'(busy_v[1]), 64'(0));
        check("t4_stream_stop_vld", 64'(valid_v[1]), 64'(0));

        // 5b: start&&stop in IDLE loads a fresh key
        model_load(80'hA5A5A5A5A5A5A5A5A5A5, 80'h00112233445566778899, 1152);
        model_push(8, 32);
        do_start(1, 80'hA5A5A5A5A5A5A5A5A5A5, 80'h00112233445566778899, 1'b1);
        check("t5_idle_start_stop_busy", 64'(busy_v[1]), 64'(1));
        ks_ready = 1'b1;
        wait_valid(1, 400, lat);
        check("t5_rekey_latency", 64'(lat), 64'(145));
        stream(1, 32, 1'b0, 1, "t5_rekey");

        // 5c: async reset mid-stream clears outputs without a clock edge
        repeat (3) @(negedge clk);
        check("t5_pre_rst_vld", 64'(valid_v[1]), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("t5_async_rst_vld", 64'(valid_v[1]), 64'(0));
        check("t5_async_rst_busy", 64'(busy_v[1]), 64'(0));
        check("t5_async_rst_dat", 64'(d1), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 6: WARMUP=16, P=4, W=16 -> 8-clock latency, 4 clocks per word, then backpressure
        model_load(80'h3C3C3C3C3C3C3C3C3C3C, 80'h8001800180018001C003, 16);
        model_push(16, 32);
        do_start(2, 80'h3C3C3C3C3C3C3C3C3C3C, 80'h8001800180018001C003, 1'b0);
        ks_ready = 1'b1;
        wait_valid(2, 100, lat);
        check("t6_latency", 64'(lat), 64'(8));
        stream(2, 32, 1'b0, 4, "t6");
        model_push(16, 64);
        stream(2, 64, 1'b1, 0, "t6_bp");
        check("final_drained", 64'(sbq.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
